// File: rtl/uart_echo_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_echo_buffer_if
//  Purpose  : Byte stream handshake bundle (tdata/tvalid/tready) used on both
//             the RX-side and TX-side ports of uart_echo_buffer.
//  Revision : 1.0  initial release
// ============================================================================

interface uart_echo_buffer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

`default_nettype wire

// File: rtl/uart_echo_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : uart_echo_buffer
//  Purpose  : DEPTH-word echo FIFO between uart RX and TX streams with per-byte
//             transform (echo/invert/case/drop) and RTS/CTS flow control.
//             Define UART_ECHO_STATS_EN to add rx/tx/drop saturating counters.
//  Revision : 1.0  initial release
// ============================================================================

module uart_echo_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int RTS_THRESH = DEPTH - 4
) (
    input  wire                          clk,
    input  wire                          rst,
    input  wire [1:0]                    mode,
    uart_echo_buffer_if.slave            s_axis,
    uart_echo_buffer_if.master           m_axis,
    input  wire                          uart_cts_n,
    output logic                         uart_rts_n,
    output logic [$clog2(DEPTH+1)-1:0]   level
`ifdef UART_ECHO_STATS_EN
    ,
    output logic [15:0]                  rx_count,
    output logic [15:0]                  tx_count,
    output logic [15:0]                  drop_count
`endif
);

    localparam int c_lvl_w = $clog2(DEPTH + 1);
    localparam int c_ptr_w = $clog2(DEPTH);

    localparam logic [c_lvl_w-1:0] c_depth      = c_lvl_w'(DEPTH);
    localparam logic [c_lvl_w-1:0] c_rts_thresh = c_lvl_w'(RTS_THRESH);
    localparam logic [c_lvl_w-1:0] c_lvl_one    = c_lvl_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one    = c_ptr_w'(1);

    localparam logic [1:0] c_mode_echo   = 2'b00;
    localparam logic [1:0] c_mode_invert = 2'b01;
    localparam logic [1:0] c_mode_case   = 2'b10;
    localparam logic [1:0] c_mode_drop   = 2'b11;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_lvl_w-1:0]    r_level;
    logic [c_lvl_w-1:0]    w_level_next;
    logic [c_lvl_w-1:0]    w_mem_count;

    logic                  r_s_tready;
    logic                  r_m_tvalid;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic                  r_rts_n;
    logic                  r_cts_meta;
    logic                  r_cts_sync;

    logic [DATA_WIDTH-1:0] w_case_data;
    logic [DATA_WIDTH-1:0] w_xform_data;
    logic                  w_mode_drop;
    logic                  w_accept;
    logic                  w_drop;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_load;

    // CTS synchroniser; resets to "not clear" so nothing leaves before the host is sampled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cts_meta <= 1'b1;
            r_cts_sync <= 1'b1;
        end else begin
            r_cts_meta <= uart_cts_n;
            r_cts_sync <= r_cts_meta;
        end
    end

    generate
        if (DATA_WIDTH == 8) begin : g_case_en
            logic w_is_upper;
            logic w_is_lower;
            assign w_is_upper  = (s_axis.tdata >= 8'h41) && (s_axis.tdata <= 8'h5A);
            assign w_is_lower  = (s_axis.tdata >= 8'h61) && (s_axis.tdata <= 8'h7A);
            assign w_case_data = s_axis.tdata ^ {2'b00, (w_is_upper | w_is_lower), 5'b00000};
        end else begin : g_case_dis
            assign w_case_data = s_axis.tdata;
        end
    endgenerate

    always_comb begin
        w_xform_data = s_axis.tdata;
        case (mode)
            c_mode_echo:   w_xform_data = s_axis.tdata;
            c_mode_invert: w_xform_data = ~s_axis.tdata;
            c_mode_case:   w_xform_data = w_case_data;
            default:       w_xform_data = s_axis.tdata;
        endcase
    end

    assign w_mode_drop = (mode == c_mode_drop);
    assign w_accept    = s_axis.tvalid && r_s_tready;
    assign w_drop      = w_accept && w_mode_drop;
    assign w_pop       = r_m_tvalid && m_axis.tready;
    assign w_mem_count = r_level - {{(c_lvl_w-1){1'b0}}, r_m_tvalid};

    // A full block can only take a word if the output register empties this cycle;
    // this also covers a late switch out of DROP while ready was still high.
    assign w_push = w_accept && !w_mode_drop && ((r_level != c_depth) || w_pop);
    assign w_load = (w_mem_count != '0) && (!r_m_tvalid || w_pop) && !r_cts_sync;

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + c_lvl_one;
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - c_lvl_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_s_tready <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_rts_n    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_load) begin
                r_rd_ptr   <= r_rd_ptr + c_ptr_one;
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= r_mem[r_rd_ptr];
            end else if (w_pop) begin
                r_m_tvalid <= 1'b0;
            end
            r_level    <= w_level_next;
            r_s_tready <= (w_level_next != c_depth) || w_mode_drop;
            r_rts_n    <= (r_level >= c_rts_thresh);
        end
    end

    // Storage array carries no reset; the pointers and level define what is valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_xform_data;
        end
    end

    assign s_axis.tready = r_s_tready;
    assign m_axis.tvalid = r_m_tvalid;
    assign m_axis.tdata  = r_m_tdata;
    assign uart_rts_n    = r_rts_n;
    assign level         = r_level;

`ifdef UART_ECHO_STATS_EN
    logic [15:0] r_rx_count;
    logic [15:0] r_tx_count;
    logic [15:0] r_drop_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_count   <= '0;
            r_tx_count   <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_accept && !w_mode_drop && (r_rx_count != 16'hFFFF)) begin
                r_rx_count <= r_rx_count + 16'd1;
            end
            if (w_pop && (r_tx_count != 16'hFFFF)) begin
                r_tx_count <= r_tx_count + 16'd1;
            end
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign rx_count   = r_rx_count;
    assign tx_count   = r_tx_count;
    assign drop_count = r_drop_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_echo_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_echo_buffer
//  Purpose  : Self-checking bench for uart_echo_buffer: transform table, drop,
//             backpressure/drain, randomized stream and async reset.
//  Revision : 1.0  initial release
// ============================================================================

module tb_uart_echo_buffer;

    localparam int DW         = 8;
    localparam int DEPTH      = 16;
    localparam int RTS_THRESH = 12;
    localparam int LW         = $clog2(DEPTH + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       uart_cts_n = 1'b0;
    logic       m_tready_drv = 1'b1;
    logic       s_tvalid_drv = 1'b0;
    logic [7:0] s_tdata_drv = 8'h00;
    wire        uart_rts_n;
    wire [LW-1:0] level;

    int checks = 0;
    int errors = 0;
    int tready_sel = 1;   // 0 low, 1 high, 2 random
    int cts_sel    = 0;   // 0 clear, 1 blocked, 2 random toggling

    uart_echo_buffer_if #(.DATA_WIDTH(DW)) s_axis ();
    uart_echo_buffer_if #(.DATA_WIDTH(DW)) m_axis ();

    assign s_axis.tvalid = s_tvalid_drv;
    assign s_axis.tdata  = s_tdata_drv;
    assign m_axis.tready = m_tready_drv;

`ifdef UART_ECHO_STATS_EN
    wire [15:0] rx_count;
    wire [15:0] tx_count;
    wire [15:0] drop_count;
`endif

    uart_echo_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .RTS_THRESH (RTS_THRESH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .s_axis     (s_axis),
        .m_axis     (m_axis),
        .uart_cts_n (uart_cts_n),
        .uart_rts_n (uart_rts_n),
        .level      (level)
`ifdef UART_ECHO_STATS_EN
        ,
        .rx_count   (rx_count),
        .tx_count   (tx_count),
        .drop_count (drop_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference transform written from the byte rules, not from bit tricks
    function automatic logic [7:0] model_xform(input logic [1:0] md, input logic [7:0] b);
        case (md)
            2'd1:    return 8'hFF - b;
            2'd2: begin
                if (b >= 8'h41 && b <= 8'h5A)      return b + 8'd32;
                else if (b >= 8'h61 && b <= 8'h7A) return b - 8'd32;
                else                               return b;
            end
            default: return b;
        endcase
    endfunction

    // Input driver for TX ready and CTS, applied just after each rising edge
    always @(posedge clk) begin
        #1;
        case (tready_sel)
            0:       m_tready_drv = 1'b0;
            1:       m_tready_drv = 1'b1;
            default: m_tready_drv = 1'($urandom_range(0, 1));
        endcase
        case (cts_sel)
            0:       uart_cts_n = 1'b0;
            1:       uart_cts_n = 1'b1;
            default: if ($urandom_range(0, 9) == 0) uart_cts_n = ~uart_cts_n;
        endcase
    end

    // Scoreboard: a queue of expected bytes; its size is the expected level
    logic [7:0] q[$];
    int         sb_lvl;
    logic [7:0] sb_exp;
    bit         hold = 1'b0;
    logic [7:0] hold_data = 8'h00;
    bit         exp_ready = 1'b0;
    bit         exp_rts = 1'b0;
    bit         exp_ready_next = 1'b1;
    bit         exp_rts_next = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_ready = 1'b0;
            exp_rts   = 1'b0;
        end else begin
            exp_ready = exp_ready_next;
            exp_rts   = exp_rts_next;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            hold           = 1'b0;
            exp_ready_next = 1'b1;
            exp_rts_next   = 1'b0;
        end else begin
            sb_lvl = q.size();
            chk("level", 32'(level), 32'(sb_lvl));
            chk("s_tready", 32'(s_axis.tready), 32'(exp_ready));
            chk("uart_rts_n", 32'(uart_rts_n), 32'(exp_rts));
            if (sb_lvl == 0) chk("tvalid_when_empty", 32'(m_axis.tvalid), 32'd0);
            if (hold) begin
                chk("tvalid_hold", 32'(m_axis.tvalid), 32'd1);
                chk("tdata_hold", 32'(m_axis.tdata), 32'(hold_data));
            end
            exp_rts_next = (sb_lvl >= RTS_THRESH);
            if (m_axis.tvalid && m_axis.tready) begin
                if (q.size() == 0) begin
                    chk("tx_unexpected", 32'(m_axis.tdata), 32'hFFFF_FFFF);
                end else begin
                    sb_exp = q.pop_front();
                    chk("tx_order", 32'(m_axis.tdata), 32'(sb_exp));
                end
            end
            if (s_axis.tvalid && s_axis.tready && mode != 2'd3)
                q.push_back(model_xform(mode, s_axis.tdata));
            hold           = m_axis.tvalid && !m_axis.tready;
            hold_data      = m_axis.tdata;
            exp_ready_next = (q.size() < DEPTH) || (mode == 2'd3);
        end
    end

    // Called just after a rising edge; returns just after the edge that took the byte
    task automatic send(input logic [1:0] md, input logic [7:0] d, input int limit, output bit ok);
        int n;
        n = 0;
        mode         = md;
        s_tdata_drv  = d;
        s_tvalid_drv = 1'b1;
        @(negedge clk);
        while (!s_axis.tready && n < limit) begin
            @(negedge clk);
            n++;
        end
        ok = s_axis.tready;
        @(posedge clk);
        #1;
        s_tvalid_drv = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_axis.tvalid && n < 40);
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (level != '0 && n < limit);
        chk(name, 32'(level), 32'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] md;
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[12];

    initial begin
        bit ok;
        int n;
        int accepted;

        vecs[0]  = '{2'd0, 8'h41, 8'h41};
        vecs[1]  = '{2'd2, 8'h61, 8'h41};
        vecs[2]  = '{2'd2, 8'h5B, 8'h5B};
        vecs[3]  = '{2'd1, 8'h0F, 8'hF0};
        vecs[4]  = '{2'd2, 8'h41, 8'h61};
        vecs[5]  = '{2'd2, 8'h5A, 8'h7A};
        vecs[6]  = '{2'd2, 8'h40, 8'h40};
        vecs[7]  = '{2'd2, 8'h7A, 8'h5A};
        vecs[8]  = '{2'd2, 8'h7B, 8'h7B};
        vecs[9]  = '{2'd2, 8'h60, 8'h60};
        vecs[10] = '{2'd1, 8'h00, 8'hFF};
        vecs[11] = '{2'd0, 8'hA5, 8'hA5};

        // Reset values
        #1;
        chk("rst_s_tready", 32'(s_axis.tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_axis.tvalid), 32'd0);
        chk("rst_m_tdata", 32'(m_axis.tdata), 32'd0);
        chk("rst_rts_n", 32'(uart_rts_n), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Transform table, each with its one-cycle latency
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].md, vecs[i].din, 50, ok);
            chk("table_accept", 32'(ok), 32'd1);
            wait_valid(n);
            chk("table_latency", 32'(n), 32'd2);
            chk("table_data", 32'(m_axis.tdata), 32'(vecs[i].dout));
            @(posedge clk);
            #1;
        end
        wait_drain("table_drain", 20);

        // Drop mode
        for (int i = 0; i < 5; i++) begin
            send(2'd3, 8'h20 + 8'(i), 20, ok);
            chk("drop_accept", 32'(ok), 32'd1);
        end
        repeat (3) @(negedge clk);
        chk("drop_level", 32'(level), 32'd0);
        chk("drop_tvalid", 32'(m_axis.tvalid), 32'd0);
`ifdef UART_ECHO_STATS_EN
        chk("drop_count", 32'(drop_count), 32'd5);
`endif
        @(posedge clk);
        #1;

        // Backpressure with CTS blocked, then drain
        cts_sel = 1;
        repeat (4) @(posedge clk);
        #1;
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            send(2'd0, 8'h30 + 8'(i), 3, ok);
            if (ok) accepted++;
        end
        chk("bp_accepted", 32'(accepted), 32'd16);
        @(negedge clk);
        chk("bp_level", 32'(level), 32'd16);
        chk("bp_s_tready", 32'(s_axis.tready), 32'd0);
        chk("bp_rts_n", 32'(uart_rts_n), 32'd1);
        chk("bp_tvalid", 32'(m_axis.tvalid), 32'd0);
        @(posedge clk);
        #1;
        cts_sel = 0;
        wait_drain("bp_drain", 200);
        chk("bp_rts_after", 32'(uart_rts_n), 32'd0);

        // Randomized stream with random TX ready and toggling CTS
        tready_sel = 2;
        cts_sel    = 2;
        for (int i = 0; i < 100; i++) begin
            send(2'($urandom_range(0, 2)), 8'($urandom), 3000, ok);
            chk("rand_accept", 32'(ok), 32'd1);
        end
        tready_sel = 1;
        cts_sel    = 0;
        wait_drain("rand_drain", 500);

        // Async reset with a held TX word and RTS asserted
        tready_sel = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 13; i++) begin
            send(2'd0, 8'h50 + 8'(i), 20, ok);
            chk("pre_rst_accept", 32'(ok), 32'd1);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_rts_n", 32'(uart_rts_n), 32'd1);
        chk("pre_rst_tvalid", 32'(m_axis.tvalid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_s_tready", 32'(s_axis.tready), 32'd0);
        chk("arst_m_tvalid", 32'(m_axis.tvalid), 32'd0);
        chk("arst_m_tdata", 32'(m_axis.tdata), 32'd0);
        chk("arst_rts_n", 32'(uart_rts_n), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        tready_sel = 1;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send(2'd0, 8'h41, 50, ok);
        chk("post_rst_accept", 32'(ok), 32'd1);
        wait_valid(n);
        chk("post_rst_latency", 32'(n), 32'd2);
        chk("post_rst_data", 32'(m_axis.tdata), 32'h41);
        @(posedge clk);
        #1;
        wait_drain("post_rst_drain", 20);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
